// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM state encoding and frame constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/sync2.sv
// Generic 2-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk from input change to q.
// Backpressure: none (free-running).
// Ports: clk, rst (async active-low), d (async input), q (synchronized output).
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling into a one-entry holding register with valid/ack.
// Latency: rx_valid rises 1 clk after the stop-bit sample (~9.5 bit periods + 3 clk after start edge).
// Backpressure: none on the line; a good frame arriving while rx_valid=1 and no ack is dropped with rx_overrun.
// Ports: clk, rst (async active-low), rx (async serial in, idle high), rx_data/rx_valid/rx_ack
//        (holding register handshake), rx_ferr (stop-bit-low pulse), rx_overrun (dropped-byte pulse).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_ferr,
    output logic       rx_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    // First sample lands half a bit after the detected start edge.
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    logic                 rxs;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 done;   // good frame completed, shreg holds the byte

    // Line idles high, so the synchronizer resets high to avoid a false start.
    sync2 #(.RST_VAL(1'b1)) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            done    <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            done    <= 1'b0;
            rx_ferr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rxs == START_LVL) begin
                        state <= ST_START;
                        cnt   <= CNT_HALF;
                    end
                end
                ST_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (rxs == START_LVL) begin
                        state <= ST_DATA;
                        idx   <= '0;
                        cnt   <= CNT_FULL;
                    end else begin
                        // Start bit gone by mid-bit: treat as a glitch.
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        shreg[idx] <= rxs;
                        cnt        <= CNT_FULL;
                        if (idx == IDX_LAST) begin
                            state <= ST_STOP;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                end
                ST_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (rxs == STOP_LVL) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        rx_ferr <= 1'b1;
                        state   <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    // Hold off until the line returns high so a long break reports once.
                    if (rxs == STOP_LVL) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Holding register: an ack in the completion cycle frees the slot for the new byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frame stream vs a byte-level model.
// Latency: n/a.
// Backpressure: bench acks automatically or by hand depending on the scenario.
module tb_uart_rx;

    localparam int CPB = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack = 1'b0;
    logic       rx_ferr;
    logic       rx_overrun;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .rx_ferr    (rx_ferr),
        .rx_overrun (rx_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: bytes the consumer should see, and flag pulse totals.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int exp_ferr = 0;
    int exp_ovr  = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    bit auto_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge: count flag-high cycles, optionally consume bytes.
    always @(negedge clk) begin
        if (rx_ferr === 1'b1) ferr_cnt++;
        if (rx_overrun === 1'b1) ovr_cnt++;
        if (auto_ack) begin
            if (rx_ack) begin
                rx_ack = 1'b0;
            end else if (rx_valid === 1'b1) begin
                got_q.push_back(rx_data);
                rx_ack = 1'b1;
            end
        end
    end

    // Caller must be at a falling edge; drives one full frame of CPB clocks per bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_lvl;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic manual_ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
        check({tag, "_ovr"}, ovr_cnt, exp_ovr);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] a;
        logic [7:0] tbl [4];
        bit bad;

        // Reset state.
        settle(3);
        check("reset_outputs", {rx_data, rx_valid, rx_ferr, rx_overrun}, 32'h0);
        rst = 1'b1;
        settle(5);

        // Single frame 0xA5, held without ack.
        send_frame(8'hA5, 1'b1);
        settle(10);
        check("a5_valid", rx_valid, 1);
        check("a5_data", rx_data, 8'hA5);
        check_flags("a5");
        settle(20);
        check("a5_held", rx_valid, 1);
        manual_ack();
        settle(2);
        check("a5_ack_clear", rx_valid, 0);
        check("a5_data_kept", rx_data, 8'hA5);

        // Back-to-back fixed bytes with auto-ack.
        auto_ack = 1'b1;
        tbl[0] = 8'h00; tbl[1] = 8'hFF; tbl[2] = 8'h55; tbl[3] = 8'h80;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i], 1'b1);
            exp_q.push_back(tbl[i]);
        end
        settle(20);
        compare_stream("b2b");
        check_flags("b2b");

        // Short glitch on the idle line, then a real frame.
        rx = 1'b0;
        settle(3);
        rx = 1'b1;
        settle(20);
        check("glitch_valid", rx_valid, 0);
        check("glitch_count", got_q.size(), 0);
        check_flags("glitch");
        b = 8'($urandom);
        send_frame(b, 1'b1);
        exp_q.push_back(b);
        settle(20);
        compare_stream("post_glitch");

        // Framing error: 0x3C with low stop bit, then 0x12.
        send_frame(8'h3C, 1'b0);
        exp_ferr++;
        settle(20);
        check("ferr_valid", rx_valid, 0);
        check_flags("ferr");
        send_frame(8'h12, 1'b1);
        exp_q.push_back(8'h12);
        settle(20);
        compare_stream("post_ferr");

        // Overrun: two frames without ack keep the first byte.
        auto_ack = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        exp_ovr++;
        settle(20);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1);
        check_flags("ovr");
        manual_ack();
        settle(2);
        check("ovr_ack_clear", rx_valid, 0);

        // Ack in the completion cycle swaps in the new byte without overrun.
        send_frame(a, 1'b1);
        settle(10);
        check("pre_swap_data", rx_data, a);
        @(negedge clk);
        fork
            send_frame(b, 1'b1);
            begin
                // Start edge seen at posedge 0; stop sample at posedge 116; load at 117.
                repeat (117) @(posedge clk);
                @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        settle(10);
        check("swap_data", rx_data, b);
        check("swap_valid", rx_valid, 1);
        check_flags("swap");
        manual_ack();
        settle(2);

        // Reset mid-frame aborts it.
        auto_ack = 1'b1;
        @(negedge clk);
        fork
            send_frame(8'h77, 1'b1);
            begin
                settle(40);
                rst = 1'b0;
                settle(2);
                check("midreset_outputs", {rx_data, rx_valid, rx_ferr, rx_overrun}, 32'h0);
            end
        join
        rst = 1'b1;
        settle(10);
        send_frame(8'h42, 1'b1);
        exp_q.push_back(8'h42);
        settle(20);
        compare_stream("post_reset");
        check_flags("post_reset");

        // Randomized frame stream with occasional bad stop bits.
        for (int f = 0; f < 24; f++) begin
            b = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            send_frame(b, !bad);
            if (bad) begin
                exp_ferr++;
                settle(12 + int'($urandom_range(0, 6)));
            end else begin
                exp_q.push_back(b);
                settle(int'($urandom_range(0, 15)));
            end
        end
        settle(30);
        compare_stream("rand");
        check_flags("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
